uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, giving the frame payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; every register is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port P_DATA, input, DATAWIDTH bits, the parallel payload.
REQ-005 The block SHALL have port Data_Valid, input, 1 bit, a one-cycle request to transmit P_DATA.
REQ-006 The block SHALL have port PAR_EN, input, 1 bit, which inserts a parity bit in the frame when 1.
REQ-007 The block SHALL have port par_bit, input, 1 bit, the parity value from the upstream parity calculator, valid from the cycle after Data_Valid.
REQ-008 The block SHALL have port TX_OUT, output, 1 bit, the serial line, which idles high.
REQ-009 The block SHALL have port busy, output, 1 bit, which is high while a frame is in flight.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, TX_OUT=1 and busy=0; Data_Valid=1 in IDLE SHALL latch P_DATA and PAR_EN and move to START on the next edge.
REQ-012 In START, TX_OUT=0 and busy=1 for exactly one cycle, so TX_OUT falls in the cycle after the accepting edge.
REQ-013 In DATA, TX_OUT SHALL carry the latched bits LSB first, one bit per cycle, for DATAWIDTH cycles, using a bit counter of width $clog2(DATAWIDTH).
REQ-014 After the last data bit, the FSM SHALL go to PARITY if the latched PAR_EN=1, otherwise to STOP.
REQ-015 In PARITY, TX_OUT SHALL equal par_bit as sampled during that cycle, for one cycle.
REQ-016 In STOP, TX_OUT=1 and busy=1 for one cycle, then the FSM SHALL return to IDLE.
REQ-017 A frame SHALL last DATAWIDTH+3 cycles with parity and DATAWIDTH+2 cycles without.
REQ-018 Data_Valid while busy=1 SHALL be ignored: no restart and no change to the latched data or PAR_EN.
REQ-019 Integration constraint: upstream SHALL NOT pulse Data_Valid while busy=1, because the parity source re-latches on every pulse.
REQ-020 Data_Valid in the IDLE cycle that directly follows STOP SHALL be accepted normally, giving a minimum inter-frame gap of one idle cycle.
REQ-021 A change of PAR_EN mid-frame SHALL have no effect on the current frame.
REQ-022 TX_OUT and busy SHALL be registered outputs, free of combinational paths from the inputs.

Reset
REQ-023 rst=0 SHALL asynchronously force the FSM to IDLE, TX_OUT=1, busy=0, and clear the bit counter, shift register and latched PAR_EN to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with no partial stop bit sent.
REQ-025 After rst deasserts, the first Data_Valid SHALL start a complete frame.

Configuration
REQ-026 With macro UART_TX_STOP2_EN defined, STOP SHALL last two cycles (TX_OUT=1, busy=1), and frame length SHALL increase by one cycle.
REQ-027 Without UART_TX_STOP2_EN, STOP SHALL last exactly one cycle.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state encoding localparams (IDLE, START, DATA, PARITY, STOP), the START_BIT=0 and STOP_BIT=1 constants, and the default DATAWIDTH.
REQ-029 Sub-module uart_tx_serializer SHALL hold the load/shift register and bit counter, with inputs load, shift_en and P_DATA, and outputs ser_bit and ser_done.
REQ-030 ser_done SHALL pulse on the last data-bit cycle.
REQ-031 The FSM and output registers SHALL live in uart_tx_ctrl.

Verification
REQ-032 Reset, then P_DATA=8'hA5, PAR_EN=1, par_bit=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles, starting the cycle after the accepting edge, with busy high for those 11 cycles.
REQ-033 P_DATA=8'h3C, PAR_EN=0 -> TX_OUT sequence 0,0,0,1,1,1,1,0,0,1 over 10 cycles, then TX_OUT=1 and busy=0.
REQ-034 Data_Valid pulsed with P_DATA=8'hFF during the 4th data bit of an 8'h00 frame -> remaining data bits stay 0 and the frame length is unchanged.
REQ-035 rst=0 during the 5th data bit -> TX_OUT=1 and busy=0 in the same cycle; the next Data_Valid with 8'h81 -> a clean 11-cycle frame.
REQ-036 Two frames, 8'h01 then 8'h80, with Data_Valid in the IDLE cycle directly after STOP -> exactly one idle high cycle between the frames.
REQ-037 UART_TX_STOP2_EN defined, 8'h55, PAR_EN=1 -> 12-cycle frame ending with two 1s.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// line-level constants for start/stop bits and the default payload width.
// The optional second stop bit is selected with macro UART_TX_STOP2_EN.
package uart_pkg;

  localparam int DEFAULT_DATAWIDTH = 8;

  // Transmitter FSM state encoding
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Serial line levels for the framing bits
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the UART transmitter.
// load captures P_DATA and clears the counter; shift_en is held high for
// every DATA cycle and advances the register by one bit, LSB first.
// ser_bit is the bit the line must carry in the *next* cycle so the
// controller can register TX_OUT without a combinational input path:
// before the first shift it is bit 0, during DATA it is the following bit.
// ser_done pulses during the last data-bit cycle.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic [DATAWIDTH-1:0] P_DATA,
  output logic                 ser_bit,
  output logic                 ser_done
);

  localparam int                CNT_W    = $clog2(DATAWIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATAWIDTH - 1);

  logic [DATAWIDTH-1:0] r_shreg;
  logic [CNT_W-1:0]     r_cnt;

  // Capture the payload on load, then shift right once per DATA cycle
  // NOTE: the shift register is reset explicitly so that an aborted frame
  // leaves no stale payload behind; it is small, so the reset costs nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_shreg <= P_DATA;
      r_cnt   <= '0;
    end else if (shift_en) begin
      r_shreg <= r_shreg >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign ser_bit  = shift_en ? r_shreg[1] : r_shreg[0];
  assign ser_done = shift_en && (r_cnt == LAST_BIT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a DATAWIDTH-bit payload as
// start bit, data bits LSB first, optional parity bit, stop bit(s).
// TX_OUT and busy are registered from the next-state decode, so the line
// changes on the same edge that moves the FSM.
// Define UART_TX_STOP2_EN to send two stop bits instead of one.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] P_DATA,
  input  logic                 Data_Valid,
  input  logic                 PAR_EN,
  input  logic                 par_bit,
  output logic                 TX_OUT,
  output logic                 busy
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       r_tx_out;
  logic       r_busy;
  logic       r_par_en;
  logic       w_tx_next;
  logic       w_load;
  logic       w_shift_en;
  logic       w_ser_bit;
  logic       w_ser_done;
`ifdef UART_TX_STOP2_EN
  logic       r_stop_second;
`endif

  // A request is only honoured in IDLE; pulses while busy are dropped
  assign w_load     = (r_state == IDLE) && Data_Valid;
  assign w_shift_en = (r_state == DATA);

  uart_tx_serializer #(
    .DATAWIDTH (DATAWIDTH)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .shift_en (w_shift_en),
    .P_DATA   (P_DATA),
    .ser_bit  (w_ser_bit),
    .ser_done (w_ser_done)
  );

  // Next-state decode for the framing FSM
  // NOTE: w_next gets a default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Data_Valid) w_next = START;
      START:   w_next = DATA;
      DATA:    if (w_ser_done) w_next = r_par_en ? PARITY : STOP;
      PARITY:  w_next = STOP;
`ifdef UART_TX_STOP2_EN
      STOP:    if (r_stop_second) w_next = IDLE;
`else
      STOP:    w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Line level for the state being entered
  always_comb begin
    w_tx_next = STOP_BIT;
    case (w_next)
      START:   w_tx_next = START_BIT;
      DATA:    w_tx_next = w_ser_bit;
      PARITY:  w_tx_next = par_bit;
      default: w_tx_next = STOP_BIT;
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_tx_out <= STOP_BIT;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_tx_out <= w_tx_next;
      r_busy   <= (w_next != IDLE);
    end
  end

  // Parity enable is frozen at acceptance so mid-frame changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_en <= 1'b0;
    end else if (w_load) begin
      r_par_en <= PAR_EN;
    end
  end

`ifdef UART_TX_STOP2_EN
  // Marks the second STOP cycle so the FSM holds STOP for two cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stop_second <= 1'b0;
    end else begin
      r_stop_second <= (r_state == STOP) && !r_stop_second;
    end
  end
`endif

  assign TX_OUT = r_tx_out;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl. Inputs change and outputs are
// sampled 2 time units after each rising edge. Honours UART_TX_STOP2_EN.
module tb_uart_tx_ctrl;

`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       par_bit;
  logic       TX_OUT;
  logic       busy;

  int errors;
  int checks;

  uart_tx_ctrl #(
    .DATAWIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Expected line sequence, first cycle in the highest used bit
  function automatic void build(input logic [7:0] d, input logic pen, input logic par,
                                output logic [15:0] seq, output int len);
    seq = '0;
    len = 1;
    for (int i = 0; i < 8; i++) begin
      seq = {seq[14:0], d[i]};
      len++;
    end
    if (pen) begin
      seq = {seq[14:0], par};
      len++;
    end
    for (int s = 0; s < NSTOP; s++) begin
      seq = {seq[14:0], 1'b1};
      len++;
    end
  endfunction

  // Extend a hand-written single-stop vector with any extra stop bits
  function automatic void add_stops(inout logic [15:0] seq, inout int len);
    for (int s = 1; s < NSTOP; s++) begin
      seq = {seq[14:0], 1'b1};
      len++;
    end
  endfunction

  // Request one frame; returns in the START cycle
  task automatic send(input logic [7:0] d, input logic pen, input logic par);
    P_DATA     = d;
    PAR_EN     = pen;
    par_bit    = par;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  // Check a whole frame starting in its START cycle, then the idle cycle after
  task automatic run_frame(input string tag, input logic [15:0] seq, input int len);
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_tx[%0d]", tag, i), TX_OUT, seq[len-1-i]);
      check($sformatf("%s_busy[%0d]", tag, i), busy, 1'b1);
      tick();
    end
    check($sformatf("%s_idle_tx", tag), TX_OUT, 1'b1);
    check($sformatf("%s_idle_busy", tag), busy, 1'b0);
  endtask

  initial begin
    logic [15:0] seq;
    int          len;

    errors     = 0;
    checks     = 0;
    rst        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    par_bit    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick();
    check("post_rst_tx", TX_OUT, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // A5 with parity bit 0
    seq = 16'(11'b01010010101);
    len = 11;
    add_stops(seq, len);
    send(8'hA5, 1'b1, 1'b0);
    run_frame("a5", seq, len);
    tick();

    // 3C without parity
    seq = 16'(10'b0001111001);
    len = 10;
    add_stops(seq, len);
    send(8'h3C, 1'b0, 1'b1);
    run_frame("3c", seq, len);
    tick();

    // 00 frame: FF request during 4th data bit and PAR_EN flip are ignored
    build(8'h00, 1'b0, 1'b0, seq, len);
    send(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < len; i++) begin
      check($sformatf("ign_tx[%0d]", i), TX_OUT, seq[len-1-i]);
      check($sformatf("ign_busy[%0d]", i), busy, 1'b1);
      if (i == 3) PAR_EN = 1'b1;
      if (i == 4) begin
        P_DATA     = 8'hFF;
        Data_Valid = 1'b1;
      end
      if (i == 5) Data_Valid = 1'b0;
      tick();
    end
    check("ign_idle_tx", TX_OUT, 1'b1);
    check("ign_idle_busy", busy, 1'b0);
    tick();

    // Reset during the 5th data bit aborts the frame at once
    build(8'hC3, 1'b1, 1'b0, seq, len);
    send(8'hC3, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("abort_tx[%0d]", i), TX_OUT, seq[len-1-i]);
      tick();
    end
    check("abort_bit5_tx", TX_OUT, seq[len-6]);
    check("abort_bit5_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_tx", TX_OUT, 1'b1);
    check("abort_busy", busy, 1'b0);
    tick();
    check("abort_hold_tx", TX_OUT, 1'b1);
    rst = 1'b1;
    tick();
    check("abort_rel_busy", busy, 1'b0);

    // First frame after reset is complete: 81 with parity 0
    seq = 16'(11'b01000000101);
    len = 11;
    add_stops(seq, len);
    send(8'h81, 1'b1, 1'b0);
    run_frame("r81", seq, len);
    tick();

    // Back-to-back 01 then 80, second request in the idle cycle after STOP
    build(8'h01, 1'b0, 1'b0, seq, len);
    send(8'h01, 1'b0, 1'b0);
    run_frame("b01", seq, len);
    build(8'h80, 1'b0, 1'b0, seq, len);
    send(8'h80, 1'b0, 1'b0);
    run_frame("b80", seq, len);
    tick();

    // 55 with parity 0 (12 cycles and two trailing 1s when two stop bits)
    seq = 16'(11'b01010101001);
    len = 11;
    add_stops(seq, len);
    send(8'h55, 1'b1, 1'b0);
    run_frame("s55", seq, len);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
